lsu: RTL and testbench

Load/store unit between the core's memory stage and the synchronous data memory. It accepts one RV32I load or store per request handshake. For each request it drives the word-aligned data-memory address, a per-bit write mask and lane-replicated write data, then returns load data aligned to bit 0 and sign- or zero-extended to the register file. It signals `busy_o` so the core holds its pipeline while an access is in flight.

---
 rtl/proc_pkg.sv | 35 +++
 rtl/lsu_load_align.sv | 26 ++
 rtl/lsu.sv | 138 +++++++++++++
 tb/tb_lsu.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions used by the load/store unit: FSM state type,
// RV32I load/store funct3 encodings and address-offset helpers.
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LSU_F3_B  = 3'b000;
    localparam logic [2:0] LSU_F3_H  = 3'b001;
    localparam logic [2:0] LSU_F3_W  = 3'b010;
    localparam logic [2:0] LSU_F3_BU = 3'b100;
    localparam logic [2:0] LSU_F3_HU = 3'b101;

    // Halfwords ignore addr[0] and words ignore addr[1:0]: accesses are naturally aligned.
    function automatic logic [1:0] lsu_eff_off(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            LSU_F3_H, LSU_F3_HU: return {off[1], 1'b0};
            LSU_F3_W:            return 2'b00;
            default:             return off;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            LSU_F3_H, LSU_F3_HU: return off[0];
            LSU_F3_W:            return |off;
            default:             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data extractor: shifts the addressed lane down to bit 0
// and sign/zero-extends it according to funct3. Unsupported funct3 yields 0.
module lsu_load_align
    import proc_pkg::*;
(
    input  logic [31:0] dout,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = dout >> {off, 3'b000};
        case (funct3)
            LSU_F3_B:  data = {{24{shifted[7]}}, shifted[7:0]};
            LSU_F3_H:  data = {{16{shifted[15]}}, shifted[15:0]};
            LSU_F3_W:  data = shifted;
            LSU_F3_BU: data = {24'd0, shifted[7:0]};
            LSU_F3_HU: data = {16'd0, shifted[15:0]};
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit in front of a synchronous data memory with MEM_LAT read latency.
// Optional macro LSU_MISALIGN_CHK_EN: drop misaligned H/HU/W requests and pulse misalign_o.
module lsu
    import proc_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic [4:0]  resp_rd_o,
    output logic        misalign_o,
    output logic        busy_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wen_o,
    output logic [31:0] dm_din_o,
    input  logic [31:0] dm_dout_i
);

    localparam logic [1:0] WAIT_INIT = 2'(MEM_LAT - 1);

    function automatic logic [31:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            LSU_F3_B: return 32'h0000_00FF << {off, 3'b000};
            LSU_F3_H: return 32'h0000_FFFF << {off[1], 4'b0000};
            LSU_F3_W: return '1;
            default:  return '0;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            LSU_F3_B: return {4{wd[7:0]}};
            LSU_F3_H: return {2{wd[15:0]}};
            default:  return wd;
        endcase
    endfunction

    lsu_state_t  state_q, state_d;
    logic [1:0]  cnt_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic        we_q;
    logic        misal_q;
    logic        accept;
    logic        misal;
    logic [1:0]  eff_off;
    logic [31:0] load_data;

`ifdef LSU_MISALIGN_CHK_EN
    assign misal = lsu_misaligned(req_funct3_i, req_addr_i[1:0]);
`else
    assign misal = 1'b0;
`endif

    assign req_ready_o = (state_q == IDLE) && !rst_i;
    assign busy_o      = (state_q != IDLE);
    assign accept      = req_valid_i && req_ready_o;
    assign eff_off     = lsu_eff_off(req_funct3_i, req_addr_i[1:0]);

    lsu_load_align u_load_align (
        .dout   (dm_dout_i),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (load_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            // Stores and dropped misaligned requests finish after the issue cycle.
            ISSUE:   state_d = (we_q || misal_q) ? IDLE : WAIT;
            WAIT:    if (cnt_q == 2'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            off_q        <= '0;
            f3_q         <= '0;
            rd_q         <= '0;
            we_q         <= 1'b0;
            misal_q      <= 1'b0;
            dm_addr_o    <= '0;
            dm_wen_o     <= '0;
            dm_din_o     <= '0;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_rd_o    <= '0;
            misalign_o   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dm_wen_o     <= '0;
            resp_valid_o <= 1'b0;
            misalign_o   <= 1'b0;
            // Issue stage: address, mask and data become visible the cycle after accept.
            if (accept) begin
                off_q      <= eff_off;
                f3_q       <= req_funct3_i;
                rd_q       <= req_rd_i;
                we_q       <= req_we_i;
                misal_q    <= misal;
                cnt_q      <= WAIT_INIT;
                misalign_o <= misal;
                dm_addr_o  <= {req_addr_i[31:2], 2'b00};
                if (req_we_i) begin
                    dm_din_o <= store_data(req_funct3_i, req_wdata_i);
                    if (!misal) dm_wen_o <= store_mask(req_funct3_i, eff_off);
                end
            end
            // Wait stage: read data is captured on the last wait cycle.
            if (state_q == WAIT) begin
                if (cnt_q == 2'd0) begin
                    resp_valid_o <= 1'b1;
                    resp_rdata_o <= load_data;
                    resp_rd_o    <= rd_q;
                end else begin
                    cnt_q <= cnt_q - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: two instances (read latency 1 and 3),
// load responses checked through a scoreboard queue per instance.
module tb_lsu;
    import proc_pkg::*;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [2];
    logic        req_we     [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [4:0]  req_rd     [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic [4:0]  resp_rd    [2];
    logic        misalign   [2];
    logic        busy       [2];
    logic [31:0] dm_addr    [2];
    logic [31:0] dm_wen     [2];
    logic [31:0] dm_din     [2];
    logic [31:0] dm_dout    [2];

    exp_t sb0[$];
    exp_t sb1[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu #(.MEM_LAT(LAT0)) u_lsu0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
        .req_funct3_i(req_funct3[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .req_rd_i(req_rd[0]), .resp_valid_o(resp_valid[0]), .resp_rdata_o(resp_rdata[0]),
        .resp_rd_o(resp_rd[0]), .misalign_o(misalign[0]), .busy_o(busy[0]),
        .dm_addr_o(dm_addr[0]), .dm_wen_o(dm_wen[0]), .dm_din_o(dm_din[0]), .dm_dout_i(dm_dout[0])
    );

    lsu #(.MEM_LAT(LAT1)) u_lsu1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
        .req_funct3_i(req_funct3[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .req_rd_i(req_rd[1]), .resp_valid_o(resp_valid[1]), .resp_rdata_o(resp_rdata[1]),
        .resp_rd_o(resp_rd[1]), .misalign_o(misalign[1]), .busy_o(busy[1]),
        .dm_addr_o(dm_addr[1]), .dm_wen_o(dm_wen[1]), .dm_din_o(dm_din[1]), .dm_dout_i(dm_dout[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: pops the scoreboard on every resp_valid pulse.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            check("ready_busy_exclusive", {31'd0, req_ready[i] & busy[i]}, 32'd0);
            if ((i == 0 && sb0.size() != 0) || (i == 1 && sb1.size() != 0)) begin
                if (resp_valid[i]) begin
                    if (i == 0) e = sb0.pop_front();
                    else        e = sb1.pop_front();
                    check("resp_rdata", resp_rdata[i], e.data);
                    check("resp_rd", {27'd0, resp_rd[i]}, {27'd0, e.rd});
                end
            end else begin
                check("spurious_resp", {31'd0, resp_valid[i]}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_store(input int i, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_addr,
                            input logic [31:0] exp_wen, input logic [31:0] exp_din, input string tag);
        req_valid[i] = 1'b1; req_we[i] = 1'b1; req_funct3[i] = f3;
        req_addr[i] = addr; req_wdata[i] = wdata; req_rd[i] = 5'd0;
        check({tag, "_ready_T"}, {31'd0, req_ready[i]}, 32'd1);
        tick();
        req_valid[i] = 1'b0;
        check({tag, "_addr"}, dm_addr[i], exp_addr);
        check({tag, "_wen"}, dm_wen[i], exp_wen);
        if (exp_wen != 32'd0) check({tag, "_din"}, dm_din[i], exp_din);
        check({tag, "_busy_T1"}, {31'd0, busy[i]}, 32'd1);
        check({tag, "_ready_T1"}, {31'd0, req_ready[i]}, 32'd0);
        check({tag, "_misalign_T1"}, {31'd0, misalign[i]}, 32'd0);
        tick();
        check({tag, "_wen_T2"}, dm_wen[i], 32'd0);
        check({tag, "_ready_T2"}, {31'd0, req_ready[i]}, 32'd1);
    endtask

    task automatic do_load(input int i, input int lat, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] word, input logic [4:0] rd,
                           input logic [31:0] exp_data, input string tag);
        exp_t e;
        e.rd = rd;
        e.data = exp_data;
        req_valid[i] = 1'b1; req_we[i] = 1'b0; req_funct3[i] = f3;
        req_addr[i] = addr; req_wdata[i] = 32'hFFFF_FFFF; req_rd[i] = rd;
        check({tag, "_ready_T"}, {31'd0, req_ready[i]}, 32'd1);
        if (i == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        tick();
        req_valid[i] = 1'b0;
        check({tag, "_addr"}, dm_addr[i], {addr[31:2], 2'b00});
        check({tag, "_wen"}, dm_wen[i], 32'd0);
        check({tag, "_busy"}, {31'd0, busy[i]}, 32'd1);
        // Memory model: the word is present only in the cycle MEM_LAT after the address.
        for (int j = 0; j <= lat; j++) begin
            dm_dout[i] = (j == lat) ? word : 32'h5A5A_5A5A;
            check({tag, "_no_early_resp"}, {31'd0, resp_valid[i]}, 32'd0);
            tick();
        end
        dm_dout[i] = 32'hC3C3_C3C3;
        check({tag, "_resp_valid"}, {31'd0, resp_valid[i]}, 32'd1);
        check({tag, "_busy_resp"}, {31'd0, busy[i]}, 32'd1);
        tick();
        check({tag, "_resp_pulse"}, {31'd0, resp_valid[i]}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, req_ready[i]}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = 3'd0;
            req_addr[i] = 32'd0; req_wdata[i] = 32'd0; req_rd[i] = 5'd0;
            dm_dout[i] = 32'h5A5A_5A5A;
        end
        tick();
        tick();
        check("rst_ready", {31'd0, req_ready[0]}, 32'd0);
        check("rst_busy", {31'd0, busy[0]}, 32'd0);
        check("rst_dm_addr", dm_addr[0], 32'd0);
        check("rst_dm_wen", dm_wen[0], 32'd0);
        check("rst_dm_din", dm_din[0], 32'd0);
        check("rst_rdata", resp_rdata[0], 32'd0);
        check("rst_rd", {27'd0, resp_rd[0]}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
        check("rst_misalign", {31'd0, misalign[0]}, 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", {31'd0, req_ready[0]}, 32'd1);

        do_store(0, LSU_F3_B, 32'h0000_0103, 32'h1234_56A5, 32'h0000_0100,
                 32'hFF00_0000, 32'hA5A5_A5A5, "sb_103");
        do_store(0, LSU_F3_H, 32'h0000_0106, 32'h0000_BEEF, 32'h0000_0104,
                 32'hFFFF_0000, 32'hBEEF_BEEF, "sh_106");
        do_store(0, 3'b011, 32'h0000_0108, 32'h1111_2222, 32'h0000_0108,
                 32'h0000_0000, 32'h0, "st_bad_f3");

`ifdef LSU_MISALIGN_CHK_EN
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = LSU_F3_W;
        req_addr[0] = 32'h0000_0102; req_wdata[0] = 32'hCAFE_F00D;
        tick();
        req_valid[0] = 1'b0;
        check("sw_mis_pulse", {31'd0, misalign[0]}, 32'd1);
        check("sw_mis_wen", dm_wen[0], 32'd0);
        tick();
        check("sw_mis_pulse_end", {31'd0, misalign[0]}, 32'd0);
        check("sw_mis_wen_T2", dm_wen[0], 32'd0);
        check("sw_mis_idle", {31'd0, req_ready[0]}, 32'd1);
`else
        do_store(0, LSU_F3_W, 32'h0000_0102, 32'hCAFE_F00D, 32'h0000_0100,
                 32'hFFFF_FFFF, 32'hCAFE_F00D, "sw_102");
`endif

        do_load(0, LAT0, LSU_F3_B,  32'h0000_0102, 32'h0080_0000, 5'd5, 32'hFFFF_FF80, "lb_102");
        do_load(0, LAT0, LSU_F3_BU, 32'h0000_0102, 32'h0080_0000, 5'd6, 32'h0000_0080, "lbu_102");
        do_load(0, LAT0, LSU_F3_W,  32'h0000_0100, 32'h89AB_CDEF, 5'd7, 32'h89AB_CDEF, "lw_100");
        do_load(0, LAT0, LSU_F3_HU, 32'h0000_0102, 32'h8001_1234, 5'd8, 32'h0000_8001, "lhu_102");
        do_load(0, LAT0, 3'b110,    32'h0000_0100, 32'hFFFF_FFFF, 5'd9, 32'h0000_0000, "ld_bad_f3");
        do_load(1, LAT1, LSU_F3_H,  32'h0000_0102, 32'h8001_1234, 5'd17, 32'hFFFF_8001, "lh_lat3");

        // Back-to-back stores with req_valid held high.
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = LSU_F3_B;
        req_addr[0] = 32'h0000_0200; req_wdata[0] = 32'h0000_0011;
        check("b2b_ready_T", {31'd0, req_ready[0]}, 32'd1);
        tick();
        req_addr[0] = 32'h0000_0201; req_wdata[0] = 32'h0000_0022;
        check("b2b_ready_T1", {31'd0, req_ready[0]}, 32'd0);
        check("b2b_wen1", dm_wen[0], 32'h0000_00FF);
        check("b2b_din1", dm_din[0], 32'h1111_1111);
        tick();
        check("b2b_ready_T2", {31'd0, req_ready[0]}, 32'd1);
        check("b2b_wen_gap", dm_wen[0], 32'd0);
        tick();
        req_valid[0] = 1'b0;
        check("b2b_wen2", dm_wen[0], 32'h0000_FF00);
        check("b2b_din2", dm_din[0], 32'h2222_2222);
        check("b2b_addr2", dm_addr[0], 32'h0000_0200);
        tick();

        // Reset during the wait phase of a load: the load is dropped silently.
        dm_dout[1] = 32'h7777_7777;
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = LSU_F3_W;
        req_addr[1] = 32'h0000_0300; req_rd[1] = 5'd9;
        tick();
        req_valid[1] = 1'b0;
        tick();
        check("rstw_in_wait", {31'd0, busy[1]}, 32'd1);
        rst = 1'b1;
        tick();
        check("rstw_busy", {31'd0, busy[1]}, 32'd0);
        check("rstw_ready_in_rst", {31'd0, req_ready[1]}, 32'd0);
        check("rstw_dm_addr", dm_addr[1], 32'd0);
        check("rstw_dm_wen", dm_wen[1], 32'd0);
        check("rstw_dm_din", dm_din[1], 32'd0);
        check("rstw_rdata", resp_rdata[1], 32'd0);
        check("rstw_rd", {27'd0, resp_rd[1]}, 32'd0);
        check("rstw_resp_valid", {31'd0, resp_valid[1]}, 32'd0);
        rst = 1'b0;
        tick();
        check("rstw_ready_after", {31'd0, req_ready[1]}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            check("rstw_no_resp", {31'd0, resp_valid[1]}, 32'd0);
            tick();
        end

        check("sb0_drained", sb0.size(), 32'd0);
        check("sb1_drained", sb1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
